// File: rtl/arith_pkg.sv
// Shared constants and types for the arithmetic test fabric blocks.
// The divider widths mirror the 4x4 multiplier: 8-bit product, 4-bit factors.
package arith_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int ITER_CNT   = 8;
    localparam int CNT_W      = 3;

    localparam logic [DIVIDEND_W-1:0] DIV0_QUOTIENT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/divider_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface divider_if;
    import arith_pkg::*;

    // Handshake: start is sampled on the rising edge and accepted only when busy=0
    // (idle or in the done cycle); operands matter only in that accepting cycle.
    // busy is high for the iterations, then done pulses for one cycle with results
    // valid; results and div_by_zero hold until the next accepted start.
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  busy;
    logic                  done;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );

endinterface

// File: rtl/divider_addition.sv
// Existing 4-bit ripple-carry adder, reused by the divider for its trial subtract.
module addition (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       CarryIN,
    output logic [3:0] Sum,
    output logic       CarryOUT,
    output logic       overflow
);

    logic [4:0] carry;

    assign carry[0] = CarryIN;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
        assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end

    assign CarryOUT = carry[4];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign overflow = carry[4] ^ carry[3];

endmodule

// File: rtl/divider.sv
// Sequential 8-by-4 unsigned restoring divider, one quotient bit per clock.
// Zero divisors short-circuit straight to the done cycle with a saturated quotient.
module divider
    import arith_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    divider_if.slave   bus,
    output div_state_e dbg_state
);

    div_state_e state;
    div_state_e state_nxt;

    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] q_work;
    logic [DIVIDEND_W-1:0] q_next;
    logic [DIVIDEND_W-1:0] quo_r;
    logic [DIVISOR_W:0]    r_work;
    logic [DIVISOR_W:0]    r_next;
    logic [DIVISOR_W:0]    p;
    logic [DIVISOR_W-1:0]  b_q;
    logic [DIVISOR_W-1:0]  b_inv;
    logic [DIVISOR_W-1:0]  t;
    logic [DIVISOR_W-1:0]  rem_r;
    logic                  dbz_r;
    logic                  carry;
    logic                  take;
    logic                  accept;
    logic                  div_zero;
    logic                  ovf_unused;

    assign div_zero = (bus.divisor == '0);
    // The done cycle is not busy, so back-to-back requests are taken there.
    assign accept   = bus.start && (state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_nxt = div_zero ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift the next dividend bit into the partial remainder, then trial-subtract B.
    assign p     = {r_work[DIVISOR_W-1:0], q_work[DIVIDEND_W-1]};
    assign b_inv = ~b_q;

    addition u_sub (
        .A        (p[DIVISOR_W-1:0]),
        .B        (b_inv),
        .CarryIN  (1'b1),
        .Sum      (t),
        .CarryOUT (carry),
        .overflow (ovf_unused)
    );

    // A set P[4] means P >= 16 > B, so the subtract always fits in that case.
    assign take   = p[DIVISOR_W] | carry;
    assign q_next = {q_work[DIVIDEND_W-2:0], take};
    assign r_next = take ? {1'b0, t} : p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            q_work <= '0;
            r_work <= '0;
            b_q    <= '0;
            quo_r  <= '0;
            rem_r  <= '0;
            dbz_r  <= 1'b0;
        end else if (accept) begin
            if (div_zero) begin
                quo_r <= DIV0_QUOTIENT;
                rem_r <= bus.dividend[DIVISOR_W-1:0];
                dbz_r <= 1'b1;
            end else begin
                q_work <= bus.dividend;
                r_work <= '0;
                b_q    <= bus.divisor;
                cnt    <= CNT_W'(ITER_CNT - 1);
                quo_r  <= '0;
                rem_r  <= '0;
                dbz_r  <= 1'b0;
            end
        end else if (state == RUN) begin
            q_work <= q_next;
            r_work <= r_next;
            cnt    <= cnt - 1'b1;
            if (cnt == '0) begin
                quo_r <= q_next;
                rem_r <= r_next[DIVISOR_W-1:0];
            end
        end
    end

    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign dbg_state       = state;

endmodule

// File: tb/tb_divider.sv
// Bench for the divider: cycle-accurate behavioural model with per-cycle compare,
// a result scoreboard checked on each done pulse, and pinned literal cases.
module tb_divider;
    import arith_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    divider_if  bus ();
    div_state_e dbg_state;

    divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: m_k counts cycles since the accepting edge (0 = nothing in flight);
    // a job lasts 9 cycles (busy 1..8, done 9) or 1 cycle for a zero divisor.
    int         m_k    = 0;
    int         m_len  = 9;
    bit         m_zero = 1'b0;
    bit         m_dbz  = 1'b0;
    logic [7:0] m_quo  = '0;
    logic [3:0] m_rem  = '0;
    logic [7:0] pend_quo;
    logic [3:0] pend_rem;
    logic [23:0] exp_q[$];   // {dividend, divisor, quotient, remainder}

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = 0; m_zero = 1'b0; m_dbz = 1'b0; m_quo = '0; m_rem = '0;
            exp_q.delete();
        end else if (bus.start && (m_k == 0 || m_k == m_len)) begin
            m_k    = 1;
            m_zero = (bus.divisor == 0);
            m_len  = m_zero ? 1 : 9;
            if (m_zero) begin
                m_quo = 8'hFF; m_rem = bus.dividend[3:0]; m_dbz = 1'b1;
                exp_q.push_back({bus.dividend, bus.divisor, 8'hFF, bus.dividend[3:0]});
            end else begin
                m_quo = '0; m_rem = '0; m_dbz = 1'b0;
                pend_quo = 8'(bus.dividend / bus.divisor);
                pend_rem = 4'(bus.dividend % bus.divisor);
                exp_q.push_back({bus.dividend, bus.divisor, pend_quo, pend_rem});
            end
        end else if (m_k != 0) begin
            if (m_k == m_len) begin
                m_k = 0;
            end else begin
                m_k++;
                if (m_k == 9) begin
                    m_quo = pend_quo; m_rem = pend_rem;
                end
            end
        end
    end

    logic [23:0] ent;
    always @(negedge clk) begin
        if (chk_en) begin
            check("quotient",    bus.quotient,    m_quo);
            check("remainder",   bus.remainder,   m_rem);
            check("div_by_zero", bus.div_by_zero, m_dbz);
            check("busy", bus.busy, (!m_zero && m_k >= 1 && m_k <= 8) ? 1 : 0);
            check("done", bus.done, (m_k != 0 && m_k == m_len) ? 1 : 0);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL sb_empty: got done with 0 queued results at %0t", $time);
                end else begin
                    ent = exp_q.pop_front();
                    check("sb_quotient",  bus.quotient,  ent[11:4]);
                    check("sb_remainder", bus.remainder, ent[3:0]);
                    if (ent[15:12] != 0) begin
                        check("invariant", bus.quotient * ent[15:12] + bus.remainder, ent[23:16]);
                        check("rem_lt_div", (bus.remainder < ent[15:12]) ? 1 : 0, 1);
                    end
                end
            end
        end
    end

    task automatic drive_start(input logic [7:0] a, input logic [3:0] b);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.dividend = 8'($urandom); bus.divisor = 4'($urandom);
    endtask

    // Called one step after the accepting edge; returns the cycle index of done.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = -1; busy_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                cyc = i;
                return;
            end
            if (bus.busy) busy_cnt++;
        end
        n_cmp++; n_err++;
        $display("FAIL done_timeout: got no done within 20 cycles at %0t", $time);
    endtask

    task automatic run_lit(input logic [7:0] a, input logic [3:0] b,
                           input int eq, input int er, input int ecyc);
        int cyc, bc;
        drive_start(a, b);
        wait_done(cyc, bc);
        check("lit_latency",   cyc, ecyc);
        check("lit_busy_cnt",  bc, ecyc - 1);
        check("lit_quotient",  bus.quotient, eq);
        check("lit_remainder", bus.remainder, er);
        check("lit_dbz",       bus.div_by_zero, (b == 0) ? 1 : 0);
        @(negedge clk);
        check("lit_done_drop", bus.done, 0);
        check("lit_hold_q",    bus.quotient, eq);
    endtask

    initial begin
        int cyc, bc, dcnt;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check("rst_quotient",  bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_busy",      bus.busy, 0);
        check("rst_done",      bus.done, 0);
        check("rst_dbz",       bus.div_by_zero, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        run_lit(8'd200, 4'd7,  28, 4, 9);
        run_lit(8'd225, 4'd15, 15, 0, 9);
        run_lit(8'd255, 4'd15, 17, 0, 9);
        run_lit(8'd5,   4'd9,   0, 5, 9);
        run_lit(8'hA5,  4'd0, 255, 5, 1);

        // start held with junk operands through the iterations, then a DONE-cycle start.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 4'd3;
        @(posedge clk);
        for (int i = 1; i <= 8; i++) begin
            #1 bus.dividend = 8'($urandom); bus.divisor = 4'($urandom);
            @(posedge clk);
        end
        #1 bus.dividend = 8'd9; bus.divisor = 4'd2;
        @(negedge clk);
        check("hold_done",      bus.done, 1);
        check("hold_quotient",  bus.quotient, 33);
        check("hold_remainder", bus.remainder, 1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(cyc, bc);
        check("b2b_latency",   cyc, 9);
        check("b2b_quotient",  bus.quotient, 4);
        check("b2b_remainder", bus.remainder, 1);

        // Reset in cycle 4 of 200/7 abandons the job.
        drive_start(8'd200, 4'd7);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_quotient",  bus.quotient, 0);
        check("mid_rst_remainder", bus.remainder, 0);
        check("mid_rst_busy",      bus.busy, 0);
        check("mid_rst_done",      bus.done, 0);
        check("mid_rst_dbz",       bus.div_by_zero, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        check("no_done_after_rst", dcnt, 0);
        run_lit(8'd50, 4'd5, 10, 0, 9);

        // Exhaustive sweep; the compare process checks each result.
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                drive_start(8'(a), 4'(b));
                wait_done(cyc, bc);
                check("sweep_latency", cyc, 9);
            end
        end

        // Random traffic, including starts while busy and zero divisors.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            bus.start    = ($urandom_range(0, 2) == 0);
            bus.dividend = 8'($urandom);
            bus.divisor  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
